// File: rtl/miriscv_data_arbiter.sv
// Two-requester round-robin arbiter for the core's single data-memory port.
// An owner FIFO remembers who issued each accepted transaction so responses route back in order.
module miriscv_data_arbiter #(
  parameter int XLEN        = 32,
  parameter int OUTSTANDING = 2
) (
  input  logic              clk_i,
  input  logic              arst_i,

  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [XLEN/8-1:0] m0_be_i,
  input  logic [XLEN-1:0]   m0_addr_i,
  input  logic [XLEN-1:0]   m0_wdata_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  output logic [XLEN-1:0]   m0_rdata_o,

  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [XLEN/8-1:0] m1_be_i,
  input  logic [XLEN-1:0]   m1_addr_i,
  input  logic [XLEN-1:0]   m1_wdata_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [XLEN-1:0]   m1_rdata_o,

  output logic              data_req_o,
  output logic              data_we_o,
  output logic [XLEN/8-1:0] data_be_o,
  output logic [XLEN-1:0]   data_addr_o,
  output logic [XLEN-1:0]   data_wdata_o,
  input  logic              data_gnt_i,
  input  logic              data_rvalid_i,
  input  logic [XLEN-1:0]   data_rdata_i,

  output logic              arb_err_o
);

  localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CW = $clog2(OUTSTANDING + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(OUTSTANDING - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(OUTSTANDING);

  logic                   prio_q;
  logic                   lock_q;
  logic                   lock_sel_q;
  logic [CW-1:0]          cnt_q;
  logic [PW-1:0]          wr_ptr_q;
  logic [PW-1:0]          rd_ptr_q;
  logic [OUTSTANDING-1:0] owner_q;
  logic                   err_q;

  logic sel;
  logic msel_req;
  logic space;
  logic grant;
  logic resp;
  logic head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // A pending (ungranted) request keeps its owner so the downstream payload never switches.
  always_comb begin
    sel = prio_q;
    if (lock_q) begin
      sel = lock_sel_q;
    end else if (m0_req_i && !m1_req_i) begin
      sel = 1'b0;
    end else if (m1_req_i && !m0_req_i) begin
      sel = 1'b1;
    end
  end

  assign msel_req   = sel ? m1_req_i : m0_req_i;
  // Registered count only: a same-cycle response never frees a slot for this cycle's issue.
  assign space      = (cnt_q < CNT_MAX);
  assign data_req_o = ~arst_i & space & msel_req;
  assign grant      = data_req_o & data_gnt_i;
  assign m0_gnt_o   = grant & ~sel;
  assign m1_gnt_o   = grant & sel;

  always_comb begin
    data_we_o    = 1'b0;
    data_be_o    = '0;
    data_addr_o  = '0;
    data_wdata_o = '0;
    if (data_req_o) begin
      data_we_o    = sel ? m1_we_i    : m0_we_i;
      data_be_o    = sel ? m1_be_i    : m0_be_i;
      data_addr_o  = sel ? m1_addr_i  : m0_addr_i;
      data_wdata_o = sel ? m1_wdata_i : m0_wdata_i;
    end
  end

  assign head        = owner_q[rd_ptr_q];
  assign resp        = ~arst_i & data_rvalid_i & (cnt_q != '0);
  assign m0_rvalid_o = resp & ~head;
  assign m1_rvalid_o = resp & head;
  assign m0_rdata_o  = data_rdata_i;
  assign m1_rdata_o  = data_rdata_i;
  assign arb_err_o   = err_q;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      prio_q     <= 1'b0;
      lock_q     <= 1'b0;
      lock_sel_q <= 1'b0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      owner_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      if (grant) begin
        owner_q[wr_ptr_q] <= sel;
        wr_ptr_q          <= ptr_inc(wr_ptr_q);
        prio_q            <= ~sel;
        lock_q            <= 1'b0;
      end else if (data_req_o) begin
        lock_q     <= 1'b1;
        lock_sel_q <= sel;
      end

      if (resp) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end

      case ({grant, resp})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase

      // An orphan response is sticky until reset.
      if (data_rvalid_i && (cnt_q == '0)) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_miriscv_data_arbiter.sv
// Directed bench for miriscv_data_arbiter: response owners are queued at grant time
// and compared when the memory side returns data.
module tb_miriscv_data_arbiter;

  localparam int XLEN = 32;
  localparam int W    = 1;

  logic              clk = 1'b0;
  logic              arst;
  logic              m0_req, m0_we, m1_req, m1_we;
  logic [XLEN/8-1:0] m0_be, m1_be;
  logic [XLEN-1:0]   m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic              m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [XLEN-1:0]   m0_rdata, m1_rdata;
  logic              data_req, data_we;
  logic [XLEN/8-1:0] data_be;
  logic [XLEN-1:0]   data_addr, data_wdata;
  logic              data_gnt, data_rvalid;
  logic [XLEN-1:0]   data_rdata;
  logic              arb_err;

  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  miriscv_data_arbiter #(.XLEN(XLEN), .OUTSTANDING(2)) dut (
    .clk_i(clk), .arst_i(arst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_addr_i(m0_addr),
    .m0_wdata_i(m0_wdata), .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_addr_i(m1_addr),
    .m1_wdata_i(m1_wdata), .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
    .data_req_o(data_req), .data_we_o(data_we), .data_be_o(data_be), .data_addr_o(data_addr),
    .data_wdata_o(data_wdata), .data_gnt_i(data_gnt), .data_rvalid_i(data_rvalid),
    .data_rdata_i(data_rdata), .arb_err_o(arb_err)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Driver tasks
  task automatic idle();
    m0_req = 0; m0_we = 0; m0_be = '0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_be = '0; m1_addr = '0; m1_wdata = '0;
    data_gnt = 0; data_rvalid = 0; data_rdata = '0;
  endtask

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop the expected owner while data_rvalid_i is driven
  task automatic check_resp(input string tag);
    logic [W-1:0] o;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      o = exp_q.pop_front();
      chk({tag, "_rvalid0"}, {31'd0, m0_rvalid}, {31'd0, (o == 1'b0)});
      chk({tag, "_rvalid1"}, {31'd0, m1_rvalid}, {31'd0, (o == 1'b1)});
      chk({tag, "_rdata"}, o ? m1_rdata : m0_rdata, data_rdata);
    end
  endtask

  initial begin
    logic [W-1:0] owner;
    idle();
    arst = 1;
    m0_req = 1; data_rvalid = 1;
    settle();
    chk("rst_data_req", {31'd0, data_req}, 32'd0);
    chk("rst_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
    chk("rst_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
    chk("rst_err", {31'd0, arb_err}, 32'd0);
    tick();
    arst = 0;
    idle();
    tick();

    // Round-robin with continuous requests and immediate responses
    m0_req = 1; m1_req = 1; m0_addr = 32'h200; m1_addr = 32'h300; data_gnt = 1;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) begin m0_req = 0; m1_req = 0; end
      if (k > 0) begin data_rvalid = 1; data_rdata = $urandom; end
      settle();
      if (k > 0) check_resp("rr_resp");
      if (k < 4) begin
        owner = W'(k % 2);
        chk("rr_gnt0", {31'd0, m0_gnt}, {31'd0, (owner == 1'b0)});
        chk("rr_gnt1", {31'd0, m1_gnt}, {31'd0, owner});
        chk("rr_addr", data_addr, owner ? 32'h300 : 32'h200);
        exp_q.push_back(owner);
      end else begin
        chk("rr_idle_req", {31'd0, data_req}, 32'd0);
      end
      tick();
    end
    idle();

    // Lock: m1 pending, m0 arrives with priority but must wait
    m1_req = 1; m1_addr = 32'h400;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("lock_pend_addr", data_addr, 32'h400);
      chk("lock_pend_gnt", {31'd0, m1_gnt}, 32'd0);
      tick();
    end
    m0_req = 1; m0_addr = 32'h500;
    settle();
    chk("lock_addr", data_addr, 32'h400);
    chk("lock_gnt0", {31'd0, m0_gnt}, 32'd0);
    tick();
    data_gnt = 1;
    settle();
    chk("lock_m1_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd2);
    exp_q.push_back(1'b1);
    tick();
    m1_req = 0;
    settle();
    chk("lock_m0_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd1);
    chk("lock_m0_addr", data_addr, 32'h500);
    exp_q.push_back(1'b0);
    tick();

    // Full: two outstanding, m0 keeps requesting
    m0_addr = 32'h600;
    settle();
    chk("full_req", {31'd0, data_req}, 32'd0);
    chk("full_gnt0", {31'd0, m0_gnt}, 32'd0);
    chk("full_addr", data_addr, 32'd0);
    tick();
    data_rvalid = 1; data_rdata = $urandom;
    settle();
    check_resp("full_resp");
    chk("full_same_cycle_req", {31'd0, data_req}, 32'd0);
    tick();
    data_rvalid = 0;
    settle();
    chk("full_resume_req", {31'd0, data_req}, 32'd1);
    chk("full_resume_gnt", {31'd0, m0_gnt}, 32'd1);
    chk("full_resume_addr", data_addr, 32'h600);
    exp_q.push_back(1'b0);
    tick();
    m0_req = 0; data_gnt = 0;
    for (int i = 0; i < 2; i++) begin
      data_rvalid = 1; data_rdata = $urandom_range(0, 32'hFFFF);
      settle();
      check_resp("full_drain");
      tick();
    end
    idle();

    // Ordering: m0 write then m1 read
    m0_req = 1; m0_we = 1; m0_be = 4'b0110; m0_addr = 32'h700; m0_wdata = 32'hCAFEF00D;
    data_gnt = 1;
    settle();
    chk("ord_gnt0", {31'd0, m0_gnt}, 32'd1);
    chk("ord_we", {31'd0, data_we}, 32'd1);
    chk("ord_be", {28'd0, data_be}, 32'h6);
    chk("ord_wdata", data_wdata, 32'hCAFEF00D);
    exp_q.push_back(1'b0);
    tick();
    idle();
    data_gnt = 1;
    m1_req = 1; m1_addr = 32'h704; m1_be = 4'hF; m1_wdata = 32'h11111111;
    settle();
    chk("ord_gnt1", {31'd0, m1_gnt}, 32'd1);
    chk("ord_we1", {31'd0, data_we}, 32'd0);
    chk("ord_wdata1", data_wdata, 32'h11111111);
    exp_q.push_back(1'b1);
    tick();
    idle();
    data_rvalid = 1; data_rdata = 32'hAAAA0000;
    settle();
    check_resp("ord_first");
    tick();
    data_rdata = 32'h12345678;
    settle();
    check_resp("ord_second");
    tick();
    idle();

    // Single requester read with two-cycle response
    m0_req = 1; m0_addr = 32'h100; data_gnt = 1;
    settle();
    chk("single_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd1);
    chk("single_addr", data_addr, 32'h100);
    exp_q.push_back(1'b0);
    tick();
    idle();
    settle();
    chk("single_wait_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
    tick();
    data_rvalid = 1; data_rdata = 32'hDEADBEEF;
    settle();
    check_resp("single_resp");
    tick();
    idle();

    // Orphan response raises the sticky error
    data_rvalid = 1; data_rdata = 32'h5A5A5A5A;
    settle();
    chk("err_no_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
    tick();
    data_rvalid = 0;
    settle();
    chk("err_set", {31'd0, arb_err}, 32'd1);
    tick();
    settle();
    chk("err_sticky", {31'd0, arb_err}, 32'd1);
    tick();

    // Asynchronous reset mid-transaction drops ownership
    m0_req = 1; m0_addr = 32'h800; data_gnt = 1;
    settle();
    chk("rst_pre_gnt", {31'd0, m0_gnt}, 32'd1);
    tick();
    data_gnt = 0;
    #1;
    arst = 1;
    #1;
    chk("arst_err", {31'd0, arb_err}, 32'd0);
    chk("arst_req", {31'd0, data_req}, 32'd0);
    chk("arst_gnt", {31'd0, m0_gnt}, 32'd0);
    tick();
    arst = 0;
    idle();
    settle();
    chk("post_rst_req", {31'd0, data_req}, 32'd0);
    tick();
    data_rvalid = 1; data_rdata = 32'h0BADF00D;
    settle();
    chk("late_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
    tick();
    data_rvalid = 0;
    settle();
    chk("late_err", {31'd0, arb_err}, 32'd1);
    tick();

    chk("sb_drain", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/miriscv_data_arbiter.md
# miriscv_data_arbiter

Two-requester arbiter for the single data-memory port of the core. It sits between the LSU request path (requester 0) and a secondary master such as a debug or DMA engine (requester 1) on one side, and the `data_*` memory interface on the other. It holds a request stable until granted and shares the port round-robin. It tracks up to `OUTSTANDING` accepted transactions in an owner FIFO so that every `data_rvalid_i` goes back to the requester that issued it.

## Interface
- `XLEN`, 32: data and address width.
- `OUTSTANDING`, 2: maximum accepted-but-unanswered transactions (≥1). The owner FIFO depth and the counter width are derived from it.

- `clk_i` in 1: clock.
- `arst_i` in 1: reset, asynchronous and active-high.
- `m0_req_i` / `m1_req_i` in 1: request from requester 0 / 1.
- `m0_we_i` / `m1_we_i` in 1: write enable.
- `m0_be_i` / `m1_be_i` in XLEN/8: byte enables.
- `m0_addr_i` / `m1_addr_i` in XLEN: address.
- `m0_wdata_i` / `m1_wdata_i` in XLEN: write data.
- `m0_gnt_o` / `m1_gnt_o` out 1: request accepted this cycle.
- `m0_rvalid_o` / `m1_rvalid_o` out 1: response for this requester.
- `m0_rdata_o` / `m1_rdata_o` out XLEN: read data, equal to `data_rdata_i`.
- `data_req_o` out 1: downstream request.
- `data_we_o` out 1: downstream write enable.
- `data_be_o` out XLEN/8: downstream byte enables.
- `data_addr_o` out XLEN: downstream address.
- `data_wdata_o` out XLEN: downstream write data.
- `data_gnt_i` in 1: downstream accepted `data_req_o`.
- `data_rvalid_i` in 1: downstream response valid.
- `data_rdata_i` in XLEN: downstream read data.
- `arb_err_o` out 1: sticky flag, set when `data_rvalid_i` arrives with no transaction outstanding.

## Operation
State registers:
- `prio`: requester that wins a conflict. Resets to 0.
- `lock`, `lock_sel`: selection held while a request is pending.
- `cnt`: outstanding transactions, range 0..OUTSTANDING.
- Owner FIFO: 1-bit entries, with read and write pointers that wrap modulo OUTSTANDING.
- `arb_err_o` register.

Selection (`sel`):
- If `lock`=1, `sel` = `lock_sel`.
- Otherwise, if exactly one requester asserts req, `sel` is that requester.
- If both assert req, `sel` = `prio`.

Downstream request path:
- `space` = (`cnt` < OUTSTANDING).
- `data_req_o` = `space` & `msel_req`, where `msel_req` is the req of the selected requester.
- `data_we_o`, `data_be_o`, `data_addr_o` and `data_wdata_o` are muxed from `sel`, and all are 0 when `data_req_o`=0.
- `mX_gnt_o` = `data_req_o` & `data_gnt_i` & (`sel`==X).

Grant handshake (a grant occurs when `data_req_o` & `data_gnt_i`):
- Push `sel` into the owner FIFO.
- Set `prio` = ~`sel`.
- Clear `lock`.

Pending request:
- If `data_req_o`=1 and `data_gnt_i`=0, set `lock`=1 and `lock_sel`=`sel`.
- The downstream request therefore never switches requester before it is granted. Requesters hold req and payload stable until gnt.

Response handshake:
- When `data_rvalid_i`=1 and `cnt`>0, pop the FIFO head `h`.
- Drive `mh_rvalid_o`=1 and keep the other requester's rvalid at 0.
- If `data_rvalid_i`=1 with `cnt`=0: drive no rvalid, set `arb_err_o`=1 (it stays set until reset), and leave `cnt` unchanged.

Counter:
- Push only: `cnt`+1.
- Pop only: `cnt`−1.
- Push and pop in the same cycle: `cnt` unchanged, and both FIFO pointers advance.
- `space` uses the registered `cnt` only. A same-cycle pop does not free a slot for a push, which keeps the `data_rvalid_i`→`data_req_o` path free of combinational loops.

## Timing
- Grant is zero-latency: `mX_gnt_o` is combinational from `data_gnt_i` in the same cycle.
- Arbitration adds no cycle: the request reaches `data_req_o` in the same cycle it is presented.
- Response routing is combinational: `mX_rvalid_o` and `mX_rdata_o` appear in the same cycle as `data_rvalid_i`.
- While `arst_i`=1, regardless of the clock, all registers clear and outputs are forced as follows:
  - `prio`=0, `lock`=0, `cnt`=0, FIFO pointers 0, `arb_err_o`=0.
  - `data_req_o`=0, `m0_gnt_o`=`m1_gnt_o`=0, `m0_rvalid_o`=`m1_rvalid_o`=0.
- Reset in the middle of a transaction drops all outstanding ownership. A response that arrives later for such a transaction sets `arb_err_o`.
- Full condition: with `cnt`=OUTSTANDING, `data_req_o`=0 and both gnt outputs are 0. Issue resumes the cycle after the first response.
- Both requesters may have transactions interleaved in the FIFO. Responses are delivered in order.

## Test plan
- Single requester: m0 reads at 0x100, `data_gnt_i`=1 immediately, response two cycles later with rdata 0xDEADBEEF → `m0_gnt_o`=1 in cycle 0, `m0_rvalid_o`=1 with 0xDEADBEEF in cycle 2, `m1_rvalid_o`=0 throughout.
- Conflict with round-robin: m0 and m1 request continuously with `data_gnt_i`=1 and immediate responses → grants alternate m0, m1, m0, m1. The first grant goes to m0 because `prio` resets to 0.
- Lock: m1 requests alone with `data_gnt_i`=0 for 3 cycles, then m0 also asserts req → `data_addr_o` stays at m1's address until `data_gnt_i` rises, m1 is granted first, and m0 is granted in the next cycle.
- Full: OUTSTANDING=2, two grants with no response → `cnt`=2, `data_req_o`=0 while m0 still requests. One `data_rvalid_i` → `data_req_o`=1 the next cycle.
- Ordering: grant m0 (write), then m1 (read), then two responses → first response routed to m0, second to m1 with m1 receiving `data_rdata_i`. Same-cycle push and pop leaves `cnt` unchanged.
- Error and reset: `data_rvalid_i`=1 with `cnt`=0 → `arb_err_o` rises and no rvalid is issued. Asserting `arst_i` asynchronously mid-cycle → `arb_err_o`, `data_req_o` and `cnt` are 0 immediately.
